// File: rtl/alsu_pipe.sv
// alsu_pipe: parametrised two-stage arithmetic/logic/shift unit with illegal-op reporting.
// Latency: operands sampled at edge k produce out/out_valid after edge k+1; one op per cycle.
// Backpressure: none; every in_valid is accepted, and idle cycles hold all result state.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid                 qualifies A, B, opcode and all control bits this cycle
//   A, B                     WIDTH-bit unsigned operands
//   opcode                   000 AND, 001 XOR, 010 ADD, 011 MUL, 100 SHIFT, 101 ROTATE, 11x illegal
//   cin, serial_in           ADD carry-in, SHIFT fill bit
//   direction                1 = left, 0 = right (SHIFT/ROTATE)
//   red_op_A, red_op_B       reduce one operand to a single bit (AND/XOR only)
//   bypass_A, bypass_B       pass an operand straight to out
//   out, out_valid           registered 2*WIDTH-bit result and its update strobe
//   err, leds, err_count     illegal-op flag, toggle pattern, saturating illegal-op count

module alsu_pipe #(
  parameter int    WIDTH          = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           opcode,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic                 direction,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  output logic [2*WIDTH-1:0]   out,
  output logic                 out_valid,
  output logic                 err,
  output logic [15:0]          leds,
  output logic [7:0]           err_count
);

  localparam int OUT_W  = 2 * WIDTH;
  localparam bit PRIO_A = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SHF = 3'b100;
  localparam logic [2:0] OP_ROT = 3'b101;

  // ---------------------------------------------------------------------------
  // Stage 1: input capture. Operand registers only load on in_valid so that an
  // idle cycle never disturbs what stage 2 would see.
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_opcode;
  logic             s1_cin;
  logic             s1_serial;
  logic             s1_dir;
  logic             s1_red_a;
  logic             s1_red_b;
  logic             s1_byp_a;
  logic             s1_byp_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_opcode <= '0;
      s1_cin    <= 1'b0;
      s1_serial <= 1'b0;
      s1_dir    <= 1'b0;
      s1_red_a  <= 1'b0;
      s1_red_b  <= 1'b0;
      s1_byp_a  <= 1'b0;
      s1_byp_b  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= A;
        s1_b      <= B;
        s1_opcode <= opcode;
        s1_cin    <= cin;
        s1_serial <= serial_in;
        s1_dir    <= direction;
        s1_red_a  <= red_op_A;
        s1_red_b  <= red_op_B;
        s1_byp_a  <= bypass_A;
        s1_byp_b  <= bypass_B;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational result.
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] b_ext;
  logic [OUT_W-1:0] cin_ext;
  logic             bypass_any;
  logic             bypass_pick_a;
  logic             red_any;
  logic             red_pick_a;
  logic             op_illegal;
  logic [WIDTH-1:0] logic_bw;
  logic             logic_red;
  logic [OUT_W-1:0] nxt_out;
  logic             nxt_err;

  // OUT_W is exactly twice WIDTH, so a WIDTH-wide zero pad extends an operand.
  assign a_ext   = {{WIDTH{1'b0}}, s1_a};
  assign b_ext   = {{WIDTH{1'b0}}, s1_b};
  assign cin_ext = {{(OUT_W-1){1'b0}}, s1_cin & USE_CIN};

  // When both select bits are set the priority parameter breaks the tie.
  assign bypass_any    = s1_byp_a | s1_byp_b;
  assign bypass_pick_a = s1_byp_a & (~s1_byp_b | PRIO_A);
  assign red_any       = s1_red_a | s1_red_b;
  assign red_pick_a    = s1_red_a & (~s1_red_b | PRIO_A);

  // Reduction bits are only meaningful for AND/XOR; with any other opcode they
  // mark the operation illegal, as do the two unused opcodes.
  assign op_illegal = (s1_opcode[2:1] == 2'b11) ||
                      (red_any && (s1_opcode != OP_AND) && (s1_opcode != OP_XOR));

  always_comb begin
    logic_bw  = '0;
    logic_red = 1'b0;
    nxt_out   = '0;
    nxt_err   = 1'b0;

    if (s1_opcode == OP_AND) begin
      logic_bw  = s1_a & s1_b;
      logic_red = red_pick_a ? (&s1_a) : (&s1_b);
    end else begin
      logic_bw  = s1_a ^ s1_b;
      logic_red = red_pick_a ? (^s1_a) : (^s1_b);
    end

    if (bypass_any) begin
      nxt_out = bypass_pick_a ? a_ext : b_ext;
    end else if (op_illegal) begin
      nxt_out = '0;
      nxt_err = 1'b1;
    end else begin
      case (s1_opcode)
        OP_AND, OP_XOR: begin
          if (red_any) nxt_out = {{(OUT_W-1){1'b0}}, logic_red};
          else         nxt_out = {{WIDTH{1'b0}}, logic_bw};
        end
        OP_ADD: nxt_out = a_ext + b_ext + cin_ext;
        OP_MUL: nxt_out = a_ext * b_ext;
        // Shift and rotate act on the registered result, so consecutive
        // shifts chain and idle cycles in between leave out untouched.
        OP_SHF: begin
          if (s1_dir) nxt_out = {out[OUT_W-2:0], s1_serial};
          else        nxt_out = {s1_serial, out[OUT_W-1:1]};
        end
        OP_ROT: begin
          if (s1_dir) nxt_out = {out[OUT_W-2:0], out[OUT_W-1]};
          else        nxt_out = {out[0], out[OUT_W-1:1]};
        end
        default: nxt_out = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      leds      <= '0;
      err_count <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out <= nxt_out;
        err <= nxt_err;
        if (nxt_err) begin
          leds <= ~leds;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alsu_pipe.sv
// tb_alsu_pipe: directed-vector bench for alsu_pipe with two instances sharing stimulus.
// u_pa uses INPUT_PRIORITY "A" with the carry-in adder, u_pb uses "B" without carry-in.
// Expected values are hand-computed constants for WIDTH = 3 (6-bit results).

module tb_alsu_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] A = '0;
  logic [2:0] B = '0;
  logic [2:0] opcode = '0;
  logic       cin = 1'b0;
  logic       serial_in = 1'b0;
  logic       direction = 1'b0;
  logic       red_op_A = 1'b0;
  logic       red_op_B = 1'b0;
  logic       bypass_A = 1'b0;
  logic       bypass_B = 1'b0;

  logic [5:0]  pa_out, pb_out;
  logic        pa_out_valid, pb_out_valid;
  logic        pa_err, pb_err;
  logic [15:0] pa_leds, pb_leds;
  logic [7:0]  pa_err_count, pb_err_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alsu_pipe #(.WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON")) u_pa (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(pa_out), .out_valid(pa_out_valid), .err(pa_err), .leds(pa_leds),
    .err_count(pa_err_count)
  );

  alsu_pipe #(.WIDTH(3), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF")) u_pb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
    .cin(cin), .serial_in(serial_in), .direction(direction),
    .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .out(pb_out), .out_valid(pb_out_valid), .err(pb_err), .leds(pb_leds),
    .err_count(pb_err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic c, input logic ra, input logic rb,
                        input logic ba, input logic bb);
    opcode   = op;
    A        = a;
    B        = b;
    cin      = c;
    red_op_A = ra;
    red_op_B = rb;
    bypass_A = ba;
    bypass_B = bb;
  endtask

  // One in_valid pulse, then wait for the edge that delivers its result.
  task automatic run_op();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    step();
    step();
    check("rst_out",       {pa_out, pb_out}, 32'h0);
    check("rst_out_valid", {pa_out_valid, pb_out_valid}, 32'h0);
    check("rst_err_leds",  {pa_err, pa_leds, pb_err}, 32'h0);
    check("rst_err_count", {pa_err_count, pb_err_count}, 32'h0);
    rst = 1'b0;
    step();

    // ---------------- ADD 7+7+1, latency and single-cycle valid ----------------
    set_op(3'b010, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("add_valid_early", pa_out_valid, 1'b0);
    step();
    check("add_valid", pa_out_valid, 1'b1);
    check("add_cin_on", pa_out, 6'd15);
    check("add_cin_off", pb_out, 6'd14);
    check("add_err", pa_err, 1'b0);
    step();
    check("add_valid_drop", pa_out_valid, 1'b0);
    check("add_hold", pa_out, 6'd15);

    // ---------------- MUL and reductions ----------------
    set_op(3'b011, 3'd7, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op();
    check("mul_7x5", {pa_out, pb_out}, {6'd35, 6'd35});

    set_op(3'b000, 3'b111, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op();
    check("and_red_a", {pa_out, pb_out}, {6'd1, 6'd1});

    set_op(3'b001, 3'b001, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op();
    check("xor_red_both_prio_b", pb_out, 6'd0);
    check("xor_red_both_prio_a", pa_out, 6'd1);

    set_op(3'b001, 3'b101, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op();
    check("xor_bitwise", pa_out, 6'd6);

    // ---------------- illegal operations ----------------
    set_op(3'b110, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op();
    check("ill1_out", pa_out, 6'd0);
    check("ill1_err", {pa_err, pb_err}, 2'b11);
    check("ill1_leds", pa_leds, 16'hFFFF);
    check("ill1_count", pa_err_count, 8'd1);

    set_op(3'b010, 3'd1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op();
    check("ill2_err", pa_err, 1'b1);
    check("ill2_leds", pa_leds, 16'h0000);
    check("ill2_count", pa_err_count, 8'd2);

    set_op(3'b010, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op();
    check("legal_after_ill", {pa_out, pa_err}, {6'd2, 1'b0});
    check("count_holds", pa_err_count, 8'd2);

    // ---------------- bypass overrides illegal ----------------
    set_op(3'b111, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op();
    check("byp_prio_a", pa_out, 6'd5);
    check("byp_prio_b", pb_out, 6'd2);
    check("byp_err", {pa_err, pb_err}, 2'b00);
    check("byp_leds", pa_leds, 16'h0000);
    check("byp_count", pa_err_count, 8'd2);

    // ---------------- shift / rotate chain ----------------
    set_op(3'b000, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op();
    check("load_1", pa_out, 6'b000001);

    set_op(3'b100, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    serial_in = 1'b1;
    direction = 1'b1;
    in_valid  = 1'b1;
    step();
    step();
    check("shl_1", pa_out, 6'b000011);
    step();
    check("shl_2", pa_out, 6'b000111);
    in_valid = 1'b0;
    step();
    check("shl_3", pa_out, 6'b001111);
    step();
    step();
    check("gap_hold", {pa_out_valid, pa_out}, {1'b0, 6'b001111});

    opcode    = 3'b101;
    direction = 1'b0;
    serial_in = 1'b0;
    run_op();
    check("rotr", pa_out, 6'b100111);
    step();
    step();
    check("gap_hold_rot", {pa_out_valid, pa_out}, {1'b0, 6'b100111});

    opcode    = 3'b100;
    direction = 1'b0;
    serial_in = 1'b0;
    run_op();
    check("shr_0", pa_out, 6'b010011);

    // ---------------- saturation burst and mid-burst reset ----------------
    set_op(3'b110, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    // 253 edges deliver 252 illegal results on top of the existing 2.
    repeat (253) step();
    check("count_fe", pa_err_count, 8'hFE);
    repeat (8) step();
    check("count_sat", {pa_err_count, pb_err_count}, {8'hFF, 8'hFF});
    check("burst_err", {pa_out_valid, pa_err, pa_out}, {1'b1, 1'b1, 6'd0});
    // 260 illegal results in the burst leave the toggle pattern at its start.
    check("burst_leds", pa_leds, 16'h0000);

    #2;
    rst = 1'b1;
    #1;
    check("arst_out", {pa_out, pb_out}, 32'h0);
    check("arst_flags", {pa_out_valid, pa_err, pb_out_valid, pb_err}, 4'b0000);
    check("arst_count", {pa_err_count, pb_err_count}, 16'h0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    check("post_rst_idle", {pa_out_valid, pa_out}, 7'd0);

    set_op(3'b010, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op();
    check("post_rst_add_a", {pa_out_valid, pa_out}, {1'b1, 6'd6});
    check("post_rst_add_b", {pb_out_valid, pb_out}, {1'b1, 6'd5});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
